// File: rtl/ddr_cmd_sched.sv
// DDR4 command scheduler: in-order request queue, per-bank open-row tracking,
// PRE/ACT insertion, refresh handling and registered DDR4 pin encoding.
module ddr_cmd_sched #(
    parameter int BG_W  = 2,
    parameter int BA_W  = 2,
    parameter int ROW_W = 14,
    parameter int COL_W = 10,
    parameter int DEPTH = 8,
    parameter int T_RP  = 11,
    parameter int T_RCD = 11,
    parameter int T_CCD = 4,
    parameter int T_RFC = 208
) (
    input  logic             CK_c,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [BG_W-1:0]  req_bg,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic             ref_req,
    output logic             ref_ack,
    output logic [3:0]       cmd_code,
    output logic             cs_n,
    output logic             act_n,
    output logic             RAS_n_A16,
    output logic             CAS_n_A15,
    output logic             WE_n_A14,
    output logic             A17,
    output logic             A13,
    output logic             A12_BC_n,
    output logic             A11,
    output logic             A10_AP,
    output logic [9:0]       A9_A0,
    output logic [BG_W-1:0]  bg_addr,
    output logic [BA_W-1:0]  ba_addr
);

    localparam int BK_W    = BG_W + BA_W;
    localparam int NB      = 1 << BK_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int QC_W    = PTR_W + 1;
    localparam int T_MAX_0 = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_MAX_1 = (T_CCD > T_RFC) ? T_CCD : T_RFC;
    localparam int T_MAX   = (T_MAX_0 > T_MAX_1) ? T_MAX_0 : T_MAX_1;
    localparam int CNT_W   = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
    localparam logic [QC_W-1:0]  FULL   = QC_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RP,
        WAIT_RCD,
        WAIT_CCD,
        WAIT_RFC
    } state_t;

    typedef enum logic [3:0] {
        CMD_DES  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_RD   = 4'd2,
        CMD_WR   = 4'd3,
        CMD_RDA  = 4'd4,
        CMD_WRA  = 4'd5,
        CMD_PRE  = 4'd6,
        CMD_PREA = 4'd7,
        CMD_REF  = 4'd8
    } cmd_t;

    typedef struct packed {
        logic [1:0]       rtype;
        logic [BG_W-1:0]  bg;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } req_t;

    req_t             q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [QC_W-1:0]  q_count;
    logic [QC_W-1:0]  q_count_nxt;
    logic             push;
    logic             pop;
    req_t             head;
    logic [BK_W-1:0]  head_bank;
    logic [17:0]      act_row;

    logic [NB-1:0]    bank_open;
    logic [ROW_W-1:0] bank_row [NB];

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    cmd_t             cmd_nxt;
    logic [9:0]       ctrl_nxt;
    logic [9:0]       addr_nxt;
    logic [BG_W-1:0]  bg_nxt;
    logic [BA_W-1:0]  ba_nxt;

    // req_ready is registered from the count, so a slot freed by a pop only
    // becomes visible to the host one cycle later.
    assign push        = req_valid && req_ready;
    assign head        = q_mem[rd_ptr];
    assign head_bank   = {head.bg, head.ba};
    assign act_row     = 18'(head.row);
    assign q_count_nxt = q_count + QC_W'(push) - QC_W'(pop);

    always_comb begin
        cmd_nxt = CMD_DES;
        pop     = 1'b0;
        if (state == IDLE) begin
            if (ref_req) begin
                cmd_nxt = (|bank_open) ? CMD_PREA : CMD_REF;
            end else if (q_count != '0) begin
                if (!bank_open[head_bank]) begin
                    cmd_nxt = CMD_ACT;
                end else if (bank_row[head_bank] != head.row) begin
                    cmd_nxt = CMD_PRE;
                end else begin
                    pop = 1'b1;
                    case (head.rtype)
                        2'd0:    cmd_nxt = CMD_RD;
                        2'd1:    cmd_nxt = CMD_WR;
                        2'd2:    cmd_nxt = CMD_RDA;
                        default: cmd_nxt = CMD_WRA;
                    endcase
                end
            end
        end
    end

    // ctrl_nxt order: cs_n, act_n, RAS, CAS, WE, A17, A13, A12, A11, A10.
    always_comb begin
        ctrl_nxt = '1;
        addr_nxt = '1;
        bg_nxt   = '1;
        ba_nxt   = '1;
        case (cmd_nxt)
            CMD_ACT: begin
                ctrl_nxt = {2'b00, act_row[16], act_row[15], act_row[14],
                            act_row[17], act_row[13], act_row[12], act_row[11], act_row[10]};
                addr_nxt = act_row[9:0];
                bg_nxt   = head.bg;
                ba_nxt   = head.ba;
            end
            CMD_RD, CMD_RDA: begin
                ctrl_nxt = {5'b01101, 4'b1111, (cmd_nxt == CMD_RDA)};
                addr_nxt = 10'(head.col);
                bg_nxt   = head.bg;
                ba_nxt   = head.ba;
            end
            CMD_WR, CMD_WRA: begin
                ctrl_nxt = {5'b01100, 4'b1111, (cmd_nxt == CMD_WRA)};
                addr_nxt = 10'(head.col);
                bg_nxt   = head.bg;
                ba_nxt   = head.ba;
            end
            CMD_PRE: begin
                ctrl_nxt = {5'b01010, 5'b11110};
                bg_nxt   = head.bg;
                ba_nxt   = head.ba;
            end
            CMD_PREA: ctrl_nxt = {5'b01010, 5'b11111};
            CMD_REF:  ctrl_nxt = {5'b01001, 5'b11111};
            default:  ;
        endcase
    end

    // Storage without reset: stale contents are unreachable once pointers
    // and open flags are cleared.
    always_ff @(posedge CK_c) begin
        if (push) begin
            q_mem[wr_ptr] <= {req_type, req_bg, req_ba, req_row, req_col};
        end
        if (cmd_nxt == CMD_ACT) begin
            bank_row[head_bank] <= head.row;
        end
    end

    always_ff @(posedge CK_c) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            req_ready <= 1'b1;
            bank_open <= '0;
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_code  <= 4'd0;
            ref_ack   <= 1'b0;
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
             A17, A13, A12_BC_n, A11, A10_AP} <= '1;
            A9_A0     <= '1;
            bg_addr   <= '1;
            ba_addr   <= '1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            q_count   <= q_count_nxt;
            req_ready <= (q_count_nxt < FULL);

            cmd_code  <= cmd_nxt;
            ref_ack   <= (cmd_nxt == CMD_REF);
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
             A17, A13, A12_BC_n, A11, A10_AP} <= ctrl_nxt;
            A9_A0     <= addr_nxt;
            bg_addr   <= bg_nxt;
            ba_addr   <= ba_nxt;

            case (cmd_nxt)
                CMD_ACT:                   bank_open[head_bank] <= 1'b1;
                CMD_PRE, CMD_RDA, CMD_WRA: bank_open[head_bank] <= 1'b0;
                CMD_PREA:                  bank_open <= '0;
                default:                   ;
            endcase

            // A wait of N loads N-1 and leaves when the count drops to 1, so
            // the next command lands exactly N cycles after the current one.
            if (state == IDLE) begin
                case (cmd_nxt)
                    CMD_ACT: begin
                        state    <= WAIT_RCD;
                        wait_cnt <= LD_RCD;
                    end
                    CMD_PRE, CMD_PREA, CMD_RDA, CMD_WRA: begin
                        state    <= WAIT_RP;
                        wait_cnt <= LD_RP;
                    end
                    CMD_RD, CMD_WR: begin
                        state    <= WAIT_CCD;
                        wait_cnt <= LD_CCD;
                    end
                    CMD_REF: begin
                        state    <= WAIT_RFC;
                        wait_cnt <= LD_RFC;
                    end
                    default: ;
                endcase
            end else if (wait_cnt <= CNT_W'(1)) begin
                state    <= IDLE;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed bench for ddr_cmd_sched: a monitor logs every non-DES pin cycle and
// an expectation table is compared against that log in order.
module tb_ddr_cmd_sched;

    logic       CK_c = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_type;
    logic [1:0] req_bg;
    logic [1:0] req_ba;
    logic [13:0] req_row;
    logic [9:0] req_col;
    logic       ref_req;
    logic       ref_ack;
    logic [3:0] cmd_code;
    logic       cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic       A17, A13, A12_BC_n, A11, A10_AP;
    logic [9:0] A9_A0;
    logic [1:0] bg_addr;
    logic [1:0] ba_addr;

    ddr_cmd_sched dut (
        .CK_c(CK_c), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .ref_req(ref_req), .ref_ack(ref_ack), .cmd_code(cmd_code),
        .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
        .WE_n_A14(WE_n_A14), .A17(A17), .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11),
        .A10_AP(A10_AP), .A9_A0(A9_A0), .bg_addr(bg_addr), .ba_addr(ba_addr)
    );

    always #5 CK_c = ~CK_c;

    typedef struct {
        string      name;
        int         gap;
        logic [3:0] code;
        logic [9:0] ctrl;
        logic [9:0] addr;
        logic [1:0] bg;
        logic [1:0] ba;
        logic       ack;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic [9:0] ctrl;
        logic [9:0] addr;
        logic [1:0] bg;
        logic [1:0] ba;
        logic       ack;
    } evt_t;

    localparam logic [9:0] C_ACT0 = 10'b0000000000;
    localparam logic [9:0] C_RD   = 10'b0110111110;
    localparam logic [9:0] C_RDA  = 10'b0110111111;
    localparam logic [9:0] C_WR   = 10'b0110011110;
    localparam logic [9:0] C_PRE  = 10'b0101011110;
    localparam logic [9:0] C_PREA = 10'b0101011111;
    localparam logic [9:0] C_REF  = 10'b0100111111;

    exp_t exps[$];
    evt_t evq[$];
    evt_t mon_evt;
    int   cyc      = 0;
    int   prev_cyc = 0;
    int   exp_idx  = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    function automatic logic [9:0] ctrlPins();
        return {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A17, A13, A12_BC_n, A11, A10_AP};
    endfunction

    // Anything other than a clean DES cycle is logged, including stray ref_ack.
    always @(posedge CK_c) begin
        #2;
        cyc++;
        if (mon_en && (cmd_code !== 4'd0 || ctrlPins() !== 10'h3FF || A9_A0 !== 10'h3FF ||
                       bg_addr !== 2'b11 || ba_addr !== 2'b11 || ref_ack !== 1'b0)) begin
            mon_evt.cyc  = cyc;
            mon_evt.code = cmd_code;
            mon_evt.ctrl = ctrlPins();
            mon_evt.addr = A9_A0;
            mon_evt.bg   = bg_addr;
            mon_evt.ba   = ba_addr;
            mon_evt.ack  = ref_ack;
            evq.push_back(mon_evt);
        end
    end

    function automatic void addExp(input string name, input int gap, input logic [3:0] code,
                                   input logic [9:0] ctrl, input logic [9:0] addr,
                                   input logic [1:0] bg, input logic [1:0] ba, input logic ack);
        exp_t e;
        e.name = name; e.gap = gap; e.code = code; e.ctrl = ctrl;
        e.addr = addr; e.bg = bg; e.ba = ba; e.ack = ack;
        exps.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [1:0] bg, input logic [1:0] ba,
                                 input logic [13:0] row, input logic [9:0] col, input int hold);
        req_valid = 1'b1;
        req_type  = t;
        req_bg    = bg;
        req_ba    = ba;
        req_row   = row;
        req_col   = col;
        repeat (hold) @(negedge CK_c);
        req_valid = 1'b0;
    endtask

    task automatic markNow();
        prev_cyc = cyc;
    endtask

    task automatic expectNext();
        exp_t e;
        evt_t v;
        int   waited;
        e = exps[exp_idx];
        exp_idx++;
        waited = 0;
        while (evq.size() == 0 && waited < 400) begin
            @(negedge CK_c);
            waited++;
        end
        if (evq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: no command within 400 cycles, required code %0d", e.name, e.code);
            return;
        end
        v = evq.pop_front();
        checkOutput({e.name, " gap"},  v.cyc - prev_cyc, e.gap);
        checkOutput({e.name, " code"}, v.code, e.code);
        checkOutput({e.name, " ctrl"}, v.ctrl, e.ctrl);
        checkOutput({e.name, " addr"}, v.addr, e.addr);
        checkOutput({e.name, " bg"},   v.bg,   e.bg);
        checkOutput({e.name, " ba"},   v.ba,   e.ba);
        checkOutput({e.name, " ack"},  v.ack,  e.ack);
        prev_cyc = v.cyc;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_type  = 2'd0;
        req_bg    = 2'd0;
        req_ba    = 2'd0;
        req_row   = 14'd0;
        req_col   = 10'd0;
        ref_req   = 1'b0;

        addExp("s1 ACT 1234", 1,   4'd1, 10'b0000000100, 10'h234, 2'd1, 2'd2, 1'b0);
        addExp("s1 RD 05A",   11,  4'd2, C_RD,   10'h05A, 2'd1, 2'd2, 1'b0);
        addExp("s2 WR 010",   4,   4'd3, C_WR,   10'h010, 2'd1, 2'd2, 1'b0);
        addExp("s2 WR 011",   4,   4'd3, C_WR,   10'h011, 2'd1, 2'd2, 1'b0);
        addExp("s3 ACT 010",  4,   4'd1, C_ACT0, 10'h010, 2'd2, 2'd1, 1'b0);
        addExp("s3 RD 003",   11,  4'd2, C_RD,   10'h003, 2'd2, 2'd1, 1'b0);
        addExp("s3 PRE",      4,   4'd6, C_PRE,  10'h3FF, 2'd2, 2'd1, 1'b0);
        addExp("s3 ACT 020",  11,  4'd1, C_ACT0, 10'h020, 2'd2, 2'd1, 1'b0);
        addExp("s3 RD 004",   11,  4'd2, C_RD,   10'h004, 2'd2, 2'd1, 1'b0);
        addExp("s4 RDA 005",  4,   4'd4, C_RDA,  10'h005, 2'd2, 2'd1, 1'b0);
        addExp("s4 PREA",     11,  4'd7, C_PREA, 10'h3FF, 2'd3, 2'd3, 1'b0);
        addExp("s4 REF",      11,  4'd8, C_REF,  10'h3FF, 2'd3, 2'd3, 1'b1);
        addExp("s5 ACT 003",  208, 4'd1, C_ACT0, 10'h003, 2'd0, 2'd0, 1'b0);
        addExp("s5 RD 100",   11,  4'd2, C_RD,   10'h100, 2'd0, 2'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            addExp($sformatf("s5 RD %0h", 10'h100 + k), 4, 4'd2, C_RD, 10'(10'h100 + k), 2'd0, 2'd0, 1'b0);
        end
        addExp("s6 ACT 055",       4,  4'd1, C_ACT0, 10'h055, 2'd1, 2'd1, 1'b0);
        addExp("s6 ACT 055 again", 1,  4'd1, C_ACT0, 10'h055, 2'd1, 2'd1, 1'b0);
        addExp("s6 RD 009",        11, 4'd2, C_RD,   10'h009, 2'd1, 2'd1, 1'b0);

        repeat (3) @(negedge CK_c);
        reset_n = 1'b1;
        @(negedge CK_c);
        checkOutput("reset cmd_code",  cmd_code,   4'd0);
        checkOutput("reset ctrl",      ctrlPins(), 10'h3FF);
        checkOutput("reset addr",      A9_A0,      10'h3FF);
        checkOutput("reset bg",        bg_addr,    2'b11);
        checkOutput("reset ba",        ba_addr,    2'b11);
        checkOutput("reset ref_ack",   ref_ack,    1'b0);
        checkOutput("reset req_ready", req_ready,  1'b1);
        mon_en = 1'b1;

        // Closed bank: ACT then RD after tRCD.
        applyStimulus(2'd0, 2'd1, 2'd2, 14'h1234, 10'h05A, 1);
        markNow();
        expectNext();
        expectNext();

        // Row hits on the open bank, spaced by tCCD.
        applyStimulus(2'd1, 2'd1, 2'd2, 14'h1234, 10'h010, 1);
        applyStimulus(2'd1, 2'd1, 2'd2, 14'h1234, 10'h011, 1);
        expectNext();
        expectNext();

        // Row miss forces PRE/ACT; the trailing RDA closes the bank again.
        applyStimulus(2'd0, 2'd2, 2'd1, 14'h0010, 10'h003, 1);
        applyStimulus(2'd0, 2'd2, 2'd1, 14'h0020, 10'h004, 1);
        applyStimulus(2'd2, 2'd2, 2'd1, 14'h0020, 10'h005, 1);
        for (int k = 0; k < 6; k++) expectNext();

        // Refresh with bank 1/2 still open: PREA first, then REF.
        ref_req = 1'b1;
        expectNext();
        expectNext();
        ref_req = 1'b0;

        // Fill the queue during tRFC; the ninth request must be refused.
        checkOutput("s5 ready before fill", req_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'd0, 2'd0, 2'd0, 14'h0003, 10'(10'h100 + k), 1);
            if (k == 6) checkOutput("s5 ready after 7th", req_ready, 1'b1);
        end
        checkOutput("s5 ready after 8th", req_ready, 1'b0);
        applyStimulus(2'd0, 2'd0, 2'd0, 14'h0003, 10'h1FF, 3);
        checkOutput("s5 ready while full", req_ready, 1'b0);
        expectNext();
        expectNext();
        checkOutput("s5 ready after first pop", req_ready, 1'b1);
        applyStimulus(2'd0, 2'd0, 2'd0, 14'h0003, 10'h108, 1);
        for (int k = 0; k < 8; k++) expectNext();

        // Reset in WAIT_RCD with three requests queued.
        applyStimulus(2'd0, 2'd1, 2'd1, 14'h0055, 10'h009, 1);
        applyStimulus(2'd0, 2'd0, 2'd0, 14'h0003, 10'h020, 1);
        applyStimulus(2'd1, 2'd0, 2'd0, 14'h0003, 10'h021, 1);
        expectNext();
        reset_n = 1'b0;
        @(negedge CK_c);
        reset_n = 1'b1;
        checkOutput("s6 reset cmd_code",  cmd_code,   4'd0);
        checkOutput("s6 reset ctrl",      ctrlPins(), 10'h3FF);
        checkOutput("s6 reset req_ready", req_ready,  1'b1);
        repeat (30) @(negedge CK_c);
        checkOutput("s6 silent after reset", evq.size(), 0);
        applyStimulus(2'd0, 2'd1, 2'd1, 14'h0055, 10'h009, 1);
        markNow();
        expectNext();
        expectNext();

        repeat (5) @(negedge CK_c);
        checkOutput("trailing commands", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
